// File: rtl/packet_dispatcher_pkg.sv
// Shared constants and types for the packet dispatcher slice.
package packet_dispatcher_pkg;

  // Default packet width and destination field placement
  localparam int PACKET_WIDTH       = 32;
  localparam int DEST_LSB_DEFAULT   = 0;
  localparam int DEST_WIDTH_DEFAULT = 2;

  // Input holding register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/packet_dispatcher_if.sv
// Receive/send stream bundle between the packet network and the dispatcher.
interface packet_dispatcher_if
  import packet_dispatcher_pkg::*;
#(
  parameter int DATA_WIDTH  = PACKET_WIDTH,
  parameter int CONNECT_NUM = 3
);
  logic                              RECEIVE_VALID;
  logic                              RECEIVE_READY;
  logic [DATA_WIDTH-1:0]             RECEIVE_DATA;
  logic [CONNECT_NUM-1:0]            SEND_VALID;
  logic [CONNECT_NUM-1:0]            SEND_READY;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA;
  logic                              DROP;

  modport slave (
    input  RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    output RECEIVE_READY, SEND_VALID, SEND_DATA, DROP
  );

  modport master (
    output RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    input  RECEIVE_READY, SEND_VALID, SEND_DATA, DROP
  );
endinterface

// File: rtl/packet_dispatcher_fifo.sv
// Per-output FIFO with valid/ready on both sides; head is zero when empty.
module packet_dispatcher_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  empty, full, push, pop;

  // Occupancy flags, handshakes and next pointer/storage values
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    out_valid = !empty;
    in_ready  = !full || out_ready;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
    mem_d     = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = in_data;
  end

  // Pointer and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/packet_dispatcher.sv
// 1-to-N packet router: input holding register, destination decode, DROP pulse,
// and one packet_dispatcher_fifo per output.
// Optional feature macro: DISPATCH_BROADCAST_EN (all-ones destination writes every output).
module packet_dispatcher
  import packet_dispatcher_pkg::*;
#(
  parameter int DATA_WIDTH  = PACKET_WIDTH,
  parameter int CONNECT_NUM = 3,
  parameter int DEST_LSB    = DEST_LSB_DEFAULT,
  parameter int DEST_WIDTH  = DEST_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic               CLK,
  input  logic               RST,
  packet_dispatcher_if.slave bus
);
  localparam logic [DEST_WIDTH:0] CONNECT_LIMIT = (DEST_WIDTH+1)'(CONNECT_NUM);

  hold_state_e                       state_q, state_d;
  logic [DATA_WIDTH-1:0]             hold_data_q, hold_data_d;
  logic                              drop_q, drop_d;
  logic [DEST_WIDTH-1:0]             dest;
  logic [CONNECT_NUM-1:0]            fifo_ready, fifo_valid, push_vec;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] send_data;
  logic                              consume, receive_ready, accept;

  // Destination decode: a held packet leaves only when its target(s) can take it,
  // so a blocked packet stalls everything behind it.
  always_comb begin
    dest     = hold_data_q[DEST_LSB +: DEST_WIDTH];
    push_vec = '0;
    consume  = 1'b0;
    drop_d   = 1'b0;
    if (state_q == ST_HOLD) begin
`ifdef DISPATCH_BROADCAST_EN
      if (dest == '1) begin
        if (&fifo_ready) begin
          push_vec = '1;
          consume  = 1'b1;
        end
      end else
`endif
      if ({1'b0, dest} < CONNECT_LIMIT) begin
        for (int unsigned i = 0; i < CONNECT_NUM; i++) begin
          if (dest == DEST_WIDTH'(i) && fifo_ready[i]) begin
            push_vec[i] = 1'b1;
            consume     = 1'b1;
          end
        end
      end else begin
        consume = 1'b1;
        drop_d  = 1'b1;
      end
    end
    receive_ready = (state_q == ST_EMPTY) || consume;
    accept        = bus.RECEIVE_VALID && receive_ready;
    state_d       = state_q;
    hold_data_d   = hold_data_q;
    if (accept) begin
      state_d     = ST_HOLD;
      hold_data_d = bus.RECEIVE_DATA;
    end else if (consume) begin
      state_d = ST_EMPTY;
    end
  end

  // Holding register state, data and registered DROP pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      drop_q      <= drop_d;
    end
  end

  for (genvar g = 0; g < CONNECT_NUM; g++) begin : g_out
    packet_dispatcher_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .in_valid (push_vec[g]),
      .in_ready (fifo_ready[g]),
      .in_data  (hold_data_q),
      .out_valid(fifo_valid[g]),
      .out_ready(bus.SEND_READY[g]),
      .out_data (send_data[DATA_WIDTH*g +: DATA_WIDTH])
    );
  end

  assign bus.RECEIVE_READY = receive_ready;
  assign bus.SEND_VALID    = fifo_valid;
  assign bus.SEND_DATA     = send_data;
  assign bus.DROP          = drop_q;
endmodule

// File: tb/tb_packet_dispatcher.sv
// Self-checking bench for packet_dispatcher (CONNECT_NUM=3, FIFO_DEPTH=2, DEST_WIDTH=2).
module tb_packet_dispatcher;
  import packet_dispatcher_pkg::*;

  localparam int DW  = PACKET_WIDTH;
  localparam int CN  = 3;
  localparam int DL  = 0;
  localparam int DWD = 2;
  localparam int FD  = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  packet_dispatcher_if #(.DATA_WIDTH(DW), .CONNECT_NUM(CN)) bus ();

  packet_dispatcher #(
    .DATA_WIDTH (DW),
    .CONNECT_NUM(CN),
    .DEST_LSB   (DL),
    .DEST_WIDTH (DWD),
    .FIFO_DEPTH (FD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // Random-test reference model: expected per-output packet order
  logic [DW-1:0] exp_q [CN][$];
  int            drops_exp, drops_seen, n_sent;
  bit            pending;
  bit            prev_stall [CN];
  logic [DW-1:0] prev_data  [CN];

  function automatic logic [DW-1:0] slice(input int i);
    return bus.SEND_DATA[DW*i +: DW];
  endfunction

  function automatic logic [DW-1:0] mkpkt(input logic [1:0] d);
    logic [DW-1:0] p;
    p = $urandom;
    p[DL +: DWD] = d;
    return p;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus.RECEIVE_VALID = 1'b0;
    bus.RECEIVE_DATA  = '0;
    bus.SEND_READY    = '0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // Offer a packet and hold it until the accept edge (bounded wait)
  task automatic send(input logic [DW-1:0] p);
    int n;
    bus.RECEIVE_VALID = 1'b1;
    bus.RECEIVE_DATA  = p;
    #1;
    n = 0;
    while (!bus.RECEIVE_READY && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL send_timeout: RECEIVE_READY got %b want 1 within 50 cycles", bus.RECEIVE_READY);
    end
    tick();
    bus.RECEIVE_VALID = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.SEND_VALID !== 3'b000) $display("FAIL reset_valid: got %b want 000", bus.SEND_VALID); else passes++;
    checks++; if (bus.SEND_DATA !== '0) $display("FAIL reset_data: got %h want 0", bus.SEND_DATA); else passes++;
    checks++; if (bus.RECEIVE_READY !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.RECEIVE_READY); else passes++;
    checks++; if (bus.DROP !== 1'b0) $display("FAIL reset_drop: got %b want 0", bus.DROP); else passes++;
  endtask

  task automatic test_single();
    logic [DW-1:0] p;
    do_reset();
    bus.SEND_READY = 3'b111;
    p = mkpkt(2'd1);
    send(p);
    checks++; if (bus.SEND_VALID !== 3'b000) $display("FAIL single_no_bypass: got %b want 000", bus.SEND_VALID); else passes++;
    tick();
    checks++; if (bus.SEND_VALID !== 3'b010) $display("FAIL single_valid: got %b want 010", bus.SEND_VALID); else passes++;
    checks++; if (slice(1) !== p) $display("FAIL single_data: got %h want %h", slice(1), p); else passes++;
    checks++; if (slice(0) !== '0) $display("FAIL single_idle_zero: got %h want 0", slice(0)); else passes++;
    tick();
    checks++; if (bus.SEND_VALID !== 3'b000) $display("FAIL single_drain: got %b want 000", bus.SEND_VALID); else passes++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    do_reset();
    a = mkpkt(2'd2); b = mkpkt(2'd2); c = mkpkt(2'd2);
    send(a); send(b); send(c);
    checks++; if (bus.RECEIVE_READY !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", bus.RECEIVE_READY); else passes++;
    checks++; if (bus.SEND_VALID !== 3'b100) $display("FAIL bp_valid: got %b want 100", bus.SEND_VALID); else passes++;
    checks++; if (slice(2) !== a) $display("FAIL bp_head_a: got %h want %h", slice(2), a); else passes++;
    tick();
    checks++; if (slice(2) !== a) $display("FAIL bp_stable_a: got %h want %h", slice(2), a); else passes++;
    bus.SEND_READY = 3'b100;
    tick();
    checks++; if (slice(2) !== b) $display("FAIL bp_head_b: got %h want %h", slice(2), b); else passes++;
    checks++; if (bus.RECEIVE_READY !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", bus.RECEIVE_READY); else passes++;
    tick();
    checks++; if (slice(2) !== c) $display("FAIL bp_head_c: got %h want %h", slice(2), c); else passes++;
    tick();
    checks++; if (bus.SEND_VALID !== 3'b000) $display("FAIL bp_drained: got %b want 000", bus.SEND_VALID); else passes++;
  endtask

  task automatic test_in_order_blocking();
    logic [DW-1:0] p0, p1, x, y;
    do_reset();
    p0 = mkpkt(2'd0); p1 = mkpkt(2'd0); x = mkpkt(2'd0); y = mkpkt(2'd1);
    send(p0); send(p1); send(x);
    bus.RECEIVE_VALID = 1'b1;
    bus.RECEIVE_DATA  = y;
    #1;
    checks++; if (bus.RECEIVE_READY !== 1'b0) $display("FAIL block_ready: got %b want 0", bus.RECEIVE_READY); else passes++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.SEND_VALID[1] !== 1'b0) $display("FAIL block_out1_idle: got %b want 0", bus.SEND_VALID[1]); else passes++;
    end
    bus.SEND_READY = 3'b001;
    tick();
    bus.RECEIVE_VALID = 1'b0;
    checks++; if (slice(0) !== p1) $display("FAIL block_head_p1: got %h want %h", slice(0), p1); else passes++;
    checks++; if (bus.SEND_VALID[1] !== 1'b0) $display("FAIL block_y_not_yet: got %b want 0", bus.SEND_VALID[1]); else passes++;
    tick();
    checks++; if (bus.SEND_VALID !== 3'b011) $display("FAIL block_valid: got %b want 011", bus.SEND_VALID); else passes++;
    checks++; if (slice(1) !== y) $display("FAIL block_y: got %h want %h", slice(1), y); else passes++;
    checks++; if (slice(0) !== x) $display("FAIL block_x: got %h want %h", slice(0), x); else passes++;
  endtask

`ifdef DISPATCH_BROADCAST_EN
  task automatic test_broadcast();
    logic [DW-1:0] q0, q1, bc;
    do_reset();
    q0 = mkpkt(2'd1); q1 = mkpkt(2'd1); bc = mkpkt(2'd3);
    send(q0); send(q1); send(bc);
    for (int k = 0; k < 2; k++) begin
      checks++; if (bus.SEND_VALID !== 3'b010) $display("FAIL bc_wait_valid: got %b want 010", bus.SEND_VALID); else passes++;
      checks++; if (bus.RECEIVE_READY !== 1'b0) $display("FAIL bc_wait_ready: got %b want 0", bus.RECEIVE_READY); else passes++;
      tick();
    end
    bus.SEND_READY = 3'b010;
    tick();
    checks++; if (bus.SEND_VALID !== 3'b111) $display("FAIL bc_valid: got %b want 111", bus.SEND_VALID); else passes++;
    checks++; if (slice(0) !== bc) $display("FAIL bc_out0: got %h want %h", slice(0), bc); else passes++;
    checks++; if (slice(2) !== bc) $display("FAIL bc_out2: got %h want %h", slice(2), bc); else passes++;
    checks++; if (slice(1) !== q1) $display("FAIL bc_out1_q1: got %h want %h", slice(1), q1); else passes++;
    checks++; if (bus.DROP !== 1'b0) $display("FAIL bc_no_drop: got %b want 0", bus.DROP); else passes++;
    tick();
    checks++; if (slice(1) !== bc) $display("FAIL bc_out1: got %h want %h", slice(1), bc); else passes++;
    checks++; if (bus.DROP !== 1'b0) $display("FAIL bc_no_drop2: got %b want 0", bus.DROP); else passes++;
    bus.SEND_READY = 3'b000;
  endtask
`else
  task automatic test_drop();
    logic [DW-1:0] pd, pn;
    do_reset();
    bus.SEND_READY = 3'b111;
    pd = mkpkt(2'd3); pn = mkpkt(2'd2);
    send(pd);
    checks++; if (bus.DROP !== 1'b0) $display("FAIL drop_early: got %b want 0", bus.DROP); else passes++;
    tick();
    checks++; if (bus.DROP !== 1'b1) $display("FAIL drop_pulse: got %b want 1", bus.DROP); else passes++;
    checks++; if (bus.SEND_VALID !== 3'b000) $display("FAIL drop_no_out: got %b want 000", bus.SEND_VALID); else passes++;
    tick();
    checks++; if (bus.DROP !== 1'b0) $display("FAIL drop_one_cycle: got %b want 0", bus.DROP); else passes++;
    send(pn);
    tick();
    checks++; if (bus.SEND_VALID !== 3'b100) $display("FAIL drop_next_valid: got %b want 100", bus.SEND_VALID); else passes++;
    checks++; if (slice(2) !== pn) $display("FAIL drop_next_data: got %h want %h", slice(2), pn); else passes++;
  endtask
`endif

  task automatic test_back_to_back();
    logic [DW-1:0] p [4];
    int            dst [4];
    do_reset();
    bus.SEND_READY = 3'b111;
    dst = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) p[i] = mkpkt(2'(dst[i]));
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.RECEIVE_VALID = 1'b1;
        bus.RECEIVE_DATA  = p[i];
        #1;
        checks++; if (bus.RECEIVE_READY !== 1'b1) $display("FAIL b2b_ready: got %b want 1 at pkt %0d", bus.RECEIVE_READY, i); else passes++;
      end else begin
        bus.RECEIVE_VALID = 1'b0;
      end
      tick();
      if (i >= 1) begin
        checks++; if (bus.SEND_VALID !== 3'(1 << dst[i-1])) $display("FAIL b2b_valid: got %b want %b at pkt %0d", bus.SEND_VALID, 3'(1 << dst[i-1]), i-1); else passes++;
        checks++; if (slice(dst[i-1]) !== p[i-1]) $display("FAIL b2b_data: got %h want %h at pkt %0d", slice(dst[i-1]), p[i-1], i-1); else passes++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    send(mkpkt(2'd0)); send(mkpkt(2'd0)); send(mkpkt(2'd0));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (bus.SEND_VALID !== 3'b000) $display("FAIL midrst_valid: got %b want 000", bus.SEND_VALID); else passes++;
    checks++; if (bus.RECEIVE_READY !== 1'b1) $display("FAIL midrst_ready: got %b want 1", bus.RECEIVE_READY); else passes++;
    bus.SEND_READY = 3'b111;
    tick(); tick();
    checks++; if (bus.SEND_VALID !== 3'b000) $display("FAIL midrst_no_leftover: got %b want 000", bus.SEND_VALID); else passes++;
  endtask

  // One random cycle: randomize ready, observe handshakes before the edge, score them
  task automatic rand_step();
    logic [1:0] d;
    bit         accepted;
    accepted = 1'b0;
    bus.SEND_READY = 3'($urandom);
    @(negedge CLK);
    if (bus.RECEIVE_VALID && bus.RECEIVE_READY) begin
      d = bus.RECEIVE_DATA[DL +: DWD];
`ifdef DISPATCH_BROADCAST_EN
      if (d == 2'b11) begin
        for (int i = 0; i < CN; i++) exp_q[i].push_back(bus.RECEIVE_DATA);
      end else
`endif
      if (int'(d) < CN) exp_q[d].push_back(bus.RECEIVE_DATA);
      else drops_exp++;
      accepted = 1'b1;
      n_sent++;
    end
    for (int i = 0; i < CN; i++) begin
      if (prev_stall[i]) begin
        checks++; if (slice(i) !== prev_data[i]) $display("FAIL rand_stable%0d: got %h want %h", i, slice(i), prev_data[i]); else passes++;
      end
      if (bus.SEND_VALID[i] && bus.SEND_READY[i]) begin
        checks++;
        if (exp_q[i].size() == 0) $display("FAIL rand_extra%0d: got %h want no packet", i, slice(i));
        else begin
          logic [DW-1:0] e;
          e = exp_q[i].pop_front();
          if (slice(i) !== e) $display("FAIL rand_out%0d: got %h want %h", i, slice(i), e); else passes++;
        end
      end
      prev_stall[i] = bus.SEND_VALID[i] && !bus.SEND_READY[i];
      prev_data[i]  = slice(i);
    end
    if (bus.DROP) drops_seen++;
    @(posedge CLK);
    #1;
    if (accepted) begin
      bus.RECEIVE_VALID = 1'b0;
      pending = 1'b0;
    end
  endtask

  task automatic test_random();
    int cyc;
    do_reset();
    drops_exp = 0; drops_seen = 0; n_sent = 0; pending = 1'b0; cyc = 0;
    for (int i = 0; i < CN; i++) begin
      exp_q[i].delete();
      prev_stall[i] = 1'b0;
    end
    while (n_sent < 1000 && cyc < 30000) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        bus.RECEIVE_DATA  = $urandom;
        bus.RECEIVE_VALID = 1'b1;
        pending = 1'b1;
      end
      rand_step();
      cyc++;
    end
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && cyc < 40000) begin
      rand_step();
      cyc++;
    end
    for (int k = 0; k < 4; k++) rand_step();
    checks++; if (n_sent !== 1000) $display("FAIL rand_sent: got %0d want 1000", n_sent); else passes++;
    for (int i = 0; i < CN; i++) begin
      checks++; if (exp_q[i].size() != 0) $display("FAIL rand_lost%0d: got %0d left want 0", i, exp_q[i].size()); else passes++;
    end
    checks++; if (drops_seen !== drops_exp) $display("FAIL rand_drops: got %0d want %0d", drops_seen, drops_exp); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_in_order_blocking();
`ifdef DISPATCH_BROADCAST_EN
    test_broadcast();
`else
    test_drop();
`endif
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
